// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        SelSeq,
        SelBranch,
        SelJump,
        SelJr
    } pc_sel_e;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC computation: branch/jump/register targets and the redirect priority select.
module fetch_next_pc
    import fetch_unit_pkg::*;
(
    input  logic        id_valid,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_id,
    input  logic [31:0] instr_id,
    input  logic [31:0] jr_pc,
    output logic        redirect,
    output logic [31:0] next_pc
);

    logic [31:0] pc_id_plus4;
    pc_sel_e     sel;

    // Low jr_pc bits are forced to zero and the J opcode field is not needed here.
    logic unused_bits;
    assign unused_bits = ^{jr_pc[1:0], instr_id[31:26]};

    assign pc_id_plus4 = pc_id + 32'd4;
    assign redirect    = id_valid & ~stall & (jump_reg | jump_target | jump_branch);

    always_comb begin
        sel = SelSeq;
        if (redirect) begin
            if (jump_reg) begin
                sel = SelJr;
            end else if (jump_target) begin
                sel = SelJump;
            end else begin
                sel = SelBranch;
            end
        end
    end

    always_comb begin
        next_pc = pc_f + 32'd4;
        unique case (sel)
            SelSeq:    next_pc = pc_f + 32'd4;
            SelBranch: next_pc = pc_id_plus4 + branch_offset(instr_id[15:0]);
            SelJump:   next_pc = {pc_id_plus4[31:28], instr_id[25:0], 2'b00};
            SelJr:     next_pc = {jr_pc[31:2], 2'b00};
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage -- program counter, synchronous imem interface and IF/ID register.
// Performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               jump_branch,
    input  logic               jump_target,
    input  logic               jump_reg,
    input  logic [31:0]        jr_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc_id,
    output logic [31:0]        instr_id,
    output logic               id_valid,
    output logic [31:0]        perf_instr,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_redirect
);

    logic [31:0] pc_f;
    logic        f_valid;
    logic [31:0] next_pc;
    logic        redirect;
    logic        advance;

    fetch_next_pc u_next_pc (
        .id_valid    (id_valid),
        .stall       (stall),
        .jump_branch (jump_branch),
        .jump_target (jump_target),
        .jump_reg    (jump_reg),
        .pc_f        (pc_f),
        .pc_id       (pc_id),
        .instr_id    (instr_id),
        .jr_pc       (jr_pc),
        .redirect    (redirect),
        .next_pc     (next_pc)
    );

    assign advance = f_valid & ~stall;

    // Re-present pc_f while stalled or starting up so imem_rdata stays paired with pc_f.
    assign imem_addr = (stall | ~f_valid) ? pc_f[IMEM_AW+1:2] : next_pc[IMEM_AW+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f     <= RESET_PC;
            f_valid  <= 1'b0;
            pc_id    <= 32'h0;
            instr_id <= NOP;
            id_valid <= 1'b0;
        end else if (!f_valid) begin
            f_valid <= 1'b1;
        end else if (advance) begin
            pc_id    <= pc_f;
            instr_id <= imem_rdata;
            id_valid <= 1'b1;
            pc_f     <= next_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_instr_q;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_redirect_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_instr_q    <= 32'h0;
            perf_stall_q    <= 32'h0;
            perf_redirect_q <= 32'h0;
        end else begin
            if (advance) begin
                perf_instr_q <= perf_instr_q + 32'd1;
            end
            if (f_valid && stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (redirect) begin
                perf_redirect_q <= perf_redirect_q + 32'd1;
            end
        end
    end

    assign perf_instr    = perf_instr_q;
    assign perf_stall    = perf_stall_q;
    assign perf_redirect = perf_redirect_q;
`else
    logic unused_redirect;
    assign unused_redirect = redirect;

    assign perf_instr    = 32'h0;
    assign perf_stall    = 32'h0;
    assign perf_redirect = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an architectural delay-slot model predicts the IF/ID stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jb;
    logic        jt;
    logic        jr;
    logic [31:0] jr_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        id_valid;
    logic [31:0] perf_instr;
    logic [31:0] perf_stall;
    logic [31:0] perf_redirect;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;

    // Architectural model: the instruction in ID and the address currently being fetched.
    logic [31:0] m_if_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    bit          m_fvalid;
    bit          m_idv;
    int          e_instr;
    int          e_stall;
    int          e_redir;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    fetch_unit #(
        .RESET_PC (32'h0),
        .IMEM_AW  (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .jump_branch   (jb),
        .jump_target   (jt),
        .jump_reg      (jr),
        .jr_pc         (jr_pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc_id         (pc_id),
        .instr_id      (instr_id),
        .id_valid      (id_valid),
        .perf_instr    (perf_instr),
        .perf_stall    (perf_stall),
        .perf_redirect (perf_redirect)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_mem(input int mode);
        for (int i = 0; i < 1024; i++) begin
            mem[i] = (mode == 2) ? $urandom : 32'h100 + i;
        end
        if (mode == 1) begin
            mem[4]  = 32'h1000_0003;  // beq, +3 words
            mem[8]  = 32'h0800_0040;  // j 0x100
            mem[64] = 32'h1000_FFFF;  // beq, -1 word
        end
    endtask

    task automatic model_reset();
        m_if_pc    = 32'h0;
        m_id_pc    = 32'h0;
        m_id_instr = 32'h0;
        m_fvalid   = 0;
        m_idv      = 0;
        e_instr    = 0;
        e_stall    = 0;
        e_redir    = 0;
        exp_q.delete();
        last_exp   = '{pc: 32'h0, instr: 32'h0};
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
        check("perf_instr", perf_instr, e_instr);
        check("perf_stall", perf_stall, e_stall);
        check("perf_redirect", perf_redirect, e_redir);
`else
        check("perf_instr", perf_instr, 32'h0);
        check("perf_stall", perf_stall, 32'h0);
        check("perf_redirect", perf_redirect, 32'h0);
`endif
    endtask

    task automatic check_reset_vals();
        check("rst_pc_id", pc_id, 32'h0);
        check("rst_instr_id", instr_id, 32'h0);
        check("rst_id_valid", {31'b0, id_valid}, 32'h0);
        check("rst_imem_addr", {22'b0, imem_addr}, 32'h0);
        check("rst_perf_instr", perf_instr, 32'h0);
        check("rst_perf_stall", perf_stall, 32'h0);
        check("rst_perf_redirect", perf_redirect, 32'h0);
    endtask

    // Drive one cycle of decode feedback at a negedge, predict, then advance the model.
    task automatic step(input bit st, input bit b, input bit t, input bit r,
                        input logic [31:0] rpc);
        logic [31:0] tgt;
        logic [31:0] off;
        logic [31:0] nxt;
        logic [31:0] a;
        bit          redir;
        stall = st;
        jb    = b;
        jt    = t;
        jr    = r;
        jr_pc = rpc;
        redir = m_idv && !st && (b || t || r);
        off   = {{16{m_id_instr[15]}}, m_id_instr[15:0]};
        if (r) begin
            tgt = rpc & 32'hFFFF_FFFC;
        end else if (t) begin
            tgt = ((m_id_pc + 32'd4) & 32'hF000_0000) | ((m_id_instr & 32'h03FF_FFFF) << 2);
        end else begin
            tgt = m_id_pc + 32'd4 + (off << 2);
        end
        nxt = redir ? tgt : m_if_pc + 32'd4;
        #1;
        a = (st || !m_fvalid) ? m_if_pc : nxt;
        check("imem_addr", {22'b0, imem_addr}, (a >> 2) & 32'h3FF);
        if (!m_fvalid) begin
            m_fvalid = 1;
        end else if (st) begin
            e_stall++;
        end else begin
            exp_q.push_back('{pc: m_if_pc, instr: mem[m_if_pc[11:2]]});
            e_instr++;
            if (redir) e_redir++;
            m_id_pc    = m_if_pc;
            m_id_instr = mem[m_if_pc[11:2]];
            m_idv      = 1;
            m_if_pc    = nxt;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between edges while stalled.
    task automatic pulse_reset(input int mode);
        check_perf();
        stall = 1'b1;
        jb    = 1'b0;
        jt    = 1'b0;
        jr    = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_vals();
        load_mem(mode);
        #1 rst = 1'b0;
        model_reset();
        // The startup edge falls before the next negedge, with stall still high.
        m_fvalid = 1;
        @(negedge clk);
    endtask

    task automatic phase_free_run();
        int n_st = 0;
        for (int i = 0; i < 12; i++) begin
            bit st;
            st = m_idv && (m_id_pc == 32'h8) && (n_st < 2);
            if (st) n_st++;
            step(st, 0, 0, 0, 32'h0);
        end
    endtask

    task automatic phase_directed();
        int c100 = 0;
        for (int i = 0; i < 40; i++) begin
            bit          st;
            bit          b;
            bit          t;
            bit          r;
            logic [31:0] rpc;
            st  = 0;
            b   = 0;
            t   = 0;
            r   = 0;
            rpc = 32'h0;
            if (m_idv) begin
                if (m_id_pc == 32'h10) begin
                    b = 1;
                end else if (m_id_pc == 32'h20) begin
                    t = 1;
                end else if (m_id_pc == 32'h100) begin
                    c100++;
                    if (c100 <= 3) begin
                        st = 1;
                        b  = 1;
                    end else if (c100 == 4) begin
                        b = 1;
                    end else if (c100 == 5) begin
                        r   = 1;
                        b   = 1;
                        rpc = 32'h203;
                    end
                end
            end
            step(st, b, t, r, rpc);
        end
    endtask

    task automatic phase_random();
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = $urandom_range(0, 7);
            step(($urandom_range(0, 4) == 0), (sel == 0 || sel == 3), (sel == 1 || sel == 3),
                 (sel == 2 || sel == 3), $urandom);
        end
    endtask

    // Monitor: pops an expectation on every edge that advances IF/ID, else checks the hold.
    initial begin
        forever begin
            bit   s;
            exp_t e;
            @(posedge clk);
            s = stall;
            #1;
            if (!rst) begin
                if (id_valid) begin
                    if (!s) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL advance: got pc_id %h, expected no new instruction",
                                     pc_id);
                        end else begin
                            e = exp_q.pop_front();
                            check("pc_id", pc_id, e.pc);
                            check("instr_id", instr_id, e.instr);
                            last_exp = e;
                        end
                    end else begin
                        check("pc_id_hold", pc_id, last_exp.pc);
                        check("instr_id_hold", instr_id, last_exp.instr);
                    end
                end else if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    $display("FAIL id_valid: got 0, expected 1 with pc_id %h", e.pc);
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        jb    = 1'b0;
        jt    = 1'b0;
        jr    = 1'b0;
        jr_pc = 32'h0;
        load_mem(0);
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        phase_free_run();
        pulse_reset(0);
        phase_free_run();
        pulse_reset(1);
        phase_directed();
        pulse_reset(2);
        phase_random();

        step(0, 0, 0, 0, 32'h0);
        check_perf();
        check("queue_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
